// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared state encoding and default sizing for the dmem arbiter.
// Revision : 1.0
// ============================================================================
package dmem_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_CPU_PRI    = 1'b0,
        ST_PERIPH_PRI = 1'b1
    } arb_state_t;

    localparam int c_ADDR_W_DEFAULT       = 12;
    localparam int c_DATA_W_DEFAULT       = 32;
    localparam int c_STARVE_LIMIT_DEFAULT = 4;
    localparam int c_CNT_W_DEFAULT        = 3;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : CPU memory-stage, peripheral and dmem-macro signals of the arbiter.
// Revision : 1.0
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_wren;
    logic              cpu_rden;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_q;

    logic              periph_req;
    logic              periph_wren;
    logic [ADDR_W-1:0] periph_addr;
    logic [DATA_W-1:0] periph_data;
    logic              periph_grant;
    logic              periph_rvalid;
    logic [DATA_W-1:0] periph_rdata;

    logic [ADDR_W-1:0] address_dmem;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q_dmem;

    // Arbiter side
    modport slave (
        input  cpu_addr, cpu_data, cpu_wren, cpu_rden,
        input  periph_req, periph_wren, periph_addr, periph_data,
        input  q_dmem,
        output cpu_stall, cpu_q,
        output periph_grant, periph_rvalid, periph_rdata,
        output address_dmem, data, wren
    );

    // System side: pipeline, peripheral and memory macro
    modport master (
        output cpu_addr, cpu_data, cpu_wren, cpu_rden,
        output periph_req, periph_wren, periph_addr, periph_data,
        output q_dmem,
        input  cpu_stall, cpu_q,
        input  periph_grant, periph_rvalid, periph_rdata,
        input  address_dmem, data, wren
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_starve_counter
// Brief    : Counts consecutive denied peripheral cycles; hit on the LIMIT-th.
// Revision : 1.0
// ============================================================================
module dmem_arbiter_starve_counter #(
    parameter int CNT_W = 3,
    parameter int LIMIT = 4
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_inc,
    input  wire logic i_clr,
    output logic      o_hit
);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // The limit is reached on the increment itself, so the counter restarts
    // instead of storing LIMIT; it can never wrap.
    assign o_hit = i_inc && (r_cnt >= c_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr || o_hit) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares single-port dmem between CPU memory stage and a peripheral.
// Revision : 1.0
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = c_ADDR_W_DEFAULT,
    parameter int DATA_W       = c_DATA_W_DEFAULT,
    parameter int STARVE_LIMIT = c_STARVE_LIMIT_DEFAULT,
    parameter int CNT_W        = c_CNT_W_DEFAULT
) (
    input  wire logic clock,
    input  wire logic reset,
    dmem_arbiter_if.slave bus
);
    arb_state_t        r_state;
    logic              r_rd_owner_periph;
    logic [DATA_W-1:0] r_periph_rdata;

    logic              w_cpu_access;
    logic              w_periph_grant;
    logic              w_inc;
    logic              w_clr;
    logic              w_hit;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_cpu_access   = bus.cpu_wren | bus.cpu_rden;
    assign w_periph_grant = bus.periph_req &
                            ((r_state == ST_PERIPH_PRI) | ~w_cpu_access);

    assign w_inc = bus.periph_req & ~w_periph_grant;
    assign w_clr = ~bus.periph_req | w_periph_grant;

    dmem_arbiter_starve_counter #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clock (clock),
        .reset (reset),
        .i_inc (w_inc),
        .i_clr (w_clr),
        .o_hit (w_hit)
    );

    // A forced peripheral slot lasts one cycle whether or not it was used.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_CPU_PRI;
        end else if (r_state == ST_PERIPH_PRI) begin
            r_state <= ST_CPU_PRI;
        end else if (w_hit) begin
            r_state <= ST_PERIPH_PRI;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_owner_periph <= 1'b0;
            r_periph_rdata    <= '0;
        end else begin
            r_rd_owner_periph <= w_periph_grant & ~bus.periph_wren;
            if (r_rd_owner_periph) begin
                r_periph_rdata <= bus.q_dmem;
            end
        end
    end

    assign w_addr = w_periph_grant ? bus.periph_addr : bus.cpu_addr;
    assign w_data = w_periph_grant ? bus.periph_data : bus.cpu_data;

    assign bus.address_dmem = w_addr;
    assign bus.data         = w_data;
    assign bus.wren         = w_periph_grant ? bus.periph_wren : bus.cpu_wren;

    assign bus.cpu_stall    = w_cpu_access & w_periph_grant;
    assign bus.cpu_q        = bus.q_dmem;
    assign bus.periph_grant = w_periph_grant;

    // Return data is live from dmem in the rvalid cycle, then held.
    assign bus.periph_rvalid = r_rd_owner_periph;
    assign bus.periph_rdata  = r_rd_owner_periph ? bus.q_dmem : r_periph_rdata;
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed and random scoreboard bench for dmem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;
    localparam int c_LIMIT = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W       (12),
        .DATA_W       (32),
        .STARVE_LIMIT (c_LIMIT),
        .CNT_W        (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memory macro: synchronous, one-cycle read latency
    logic [31:0] mem [0:4095];
    always @(posedge clock) begin
        if (bus.wren) mem[bus.address_dmem] <= bus.data;
        bus.q_dmem <= mem[bus.address_dmem];
    end

    // Reference model state
    logic [31:0] model_mem [0:4095];
    logic [31:0] rd_q [$];
    logic        m_rd_pending;
    logic [31:0] m_last_rdata;
    logic        m_force;
    int          m_denied;
    logic        m_cpu_pending;
    logic [31:0] m_cpu_exp;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        rd_q.delete();
        m_rd_pending  = 1'b0;
        m_last_rdata  = '0;
        m_force       = 1'b0;
        m_denied      = 0;
        m_cpu_pending = 1'b0;
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cycle(input logic cw, input logic cr, input logic [11:0] ca, input logic [31:0] cd,
                         input logic pr, input logic pw, input logic [11:0] pa, input logic [31:0] pd,
                         output logic g);
        logic        cpu_acc;
        logic        e_stall;
        logic        e_wren;
        logic [11:0] e_addr;
        logic [31:0] e_data;
        logic [31:0] e_rd;
        @(negedge clock);
        bus.cpu_wren = cw;  bus.cpu_rden = cr;  bus.cpu_addr = ca;  bus.cpu_data = cd;
        bus.periph_req = pr; bus.periph_wren = pw; bus.periph_addr = pa; bus.periph_data = pd;
        #1;
        cpu_acc = cw | cr;
        g       = pr && (m_force || !cpu_acc);
        e_stall = cpu_acc && g;
        e_wren  = g ? pw : cw;
        e_addr  = g ? pa : ca;
        e_data  = g ? pd : cd;
        chk("grant", 32'(bus.periph_grant), 32'(g));
        chk("stall", 32'(bus.cpu_stall), 32'(e_stall));
        chk("wren",  32'(bus.wren), 32'(e_wren));
        chk("addr",  32'(bus.address_dmem), 32'(e_addr));
        if (e_wren) chk("wdata", bus.data, e_data);
        chk("rvalid", 32'(bus.periph_rvalid), 32'(m_rd_pending));
        if (m_rd_pending) begin
            e_rd = rd_q.pop_front();
            m_last_rdata = e_rd;
        end
        chk("rdata", bus.periph_rdata, m_last_rdata);
        if (m_cpu_pending) chk("cpu_q", bus.cpu_q, m_cpu_exp);

        m_rd_pending  = g && !pw;
        if (g && !pw) rd_q.push_back(model_mem[pa]);
        m_cpu_pending = cr && !g;
        m_cpu_exp     = model_mem[ca];
        if (e_wren) model_mem[e_addr] = e_data;
        if (pr && !g) begin
            m_denied++;
            m_force = (m_denied == c_LIMIT);
            if (m_force) m_denied = 0;
        end else begin
            m_denied = 0;
            m_force  = 1'b0;
        end
    endtask

    task automatic idle();
        logic g;
        cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    endtask

    initial begin
        logic        g;
        logic        p_pend;
        logic        p_w;
        logic [11:0] p_a;
        logic [31:0] p_d;
        int          op;

        for (int i = 0; i < 4096; i++) begin
            mem[i]       = 32'h0;
            model_mem[i] = 32'h0;
        end
        mem[12'h010]       = 32'hDEADBEEF;
        model_mem[12'h010] = 32'hDEADBEEF;
        model_reset();
        bus.cpu_wren = 1'b0; bus.cpu_rden = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
        bus.periph_req = 1'b0; bus.periph_wren = 1'b0; bus.periph_addr = '0; bus.periph_data = '0;

        // Reset state
        #2;
        chk("rst_grant",  32'(bus.periph_grant), 32'd0);
        chk("rst_stall",  32'(bus.cpu_stall), 32'd0);
        chk("rst_rvalid", 32'(bus.periph_rvalid), 32'd0);
        chk("rst_rdata",  bus.periph_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Idle CPU: peripheral read granted at once, data next cycle
        cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h010, 32'h0, g);
        idle();
        idle();

        // Reset while a peripheral read is in flight
        cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h010, 32'h0, g);
        bus.periph_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrd_rvalid", 32'(bus.periph_rvalid), 32'd0);
        chk("midrd_rdata",  bus.periph_rdata, 32'd0);
        chk("midrd_grant",  32'(bus.periph_grant), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        idle();

        // CPU loads every cycle with peripheral held: four denials, then forced slot
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, 12'(i), 32'h0, 1'b1, 1'b0, 12'h010, 32'h0, g);
        cycle(1'b0, 1'b1, 12'h010, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
        idle();

        // Collision: CPU store wins, peripheral write lands afterwards
        cycle(1'b1, 1'b0, 12'h020, 32'h5, 1'b1, 1'b1, 12'h020, 32'h9, g);
        cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 12'h020, 32'h9, g);
        cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0, g);
        idle();
        chk("collide_mem", mem[12'h020], 32'h9);

        // Request dropped exactly as the forced slot opens
        for (int i = 0; i < c_LIMIT; i++)
            cycle(1'b0, 1'b1, 12'h020, 32'h0, 1'b1, 1'b0, 12'h030, 32'h0, g);
        cycle(1'b0, 1'b1, 12'h020, 32'h0, 1'b0, 1'b0, 12'h030, 32'h0, g);
        cycle(1'b0, 1'b1, 12'h020, 32'h0, 1'b1, 1'b0, 12'h030, 32'h0, g);
        cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h030, 32'h0, g);
        idle();

        // Random mix on a small address window
        p_pend = 1'b0; p_w = 1'b0; p_a = '0; p_d = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!p_pend) begin
                p_pend = ($urandom_range(0, 1) == 1);
                p_w    = ($urandom_range(0, 1) == 1);
                p_a    = 12'($urandom_range(0, 15));
                p_d    = $urandom;
            end
            op = $urandom_range(0, 3);
            cycle(op == 3, op == 1 || op == 2, 12'($urandom_range(0, 15)), $urandom,
                  p_pend, p_w, p_a, p_d, g);
            if (g) p_pend = 1'b0;
        end
        idle();
        idle();
        for (int a = 0; a < 16; a++)
            chk("final_mem", mem[a], model_mem[a]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
